// File: rtl/nco_ctrl_pkg.sv
// Shared definitions for the NCO tuning sequencer: FSM state encoding and
// the default NCO pipeline latency.
package nco_ctrl_pkg;

    // Must track the out_valid latency of the NCO wrapper.
    localparam int NCO_LAT_DEFAULT = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        SETTLE = 2'd2
    } state_t;

endpackage

// File: rtl/nco_ctrl_dwell_cnt.sv
// Loadable down-counter with enable and zero flag; used for dwell and
// settle timing. Load has priority over enable and the count stops at zero.
module nco_ctrl_dwell_cnt
    import nco_ctrl_pkg::*;
#(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] load_val,
    input  logic             en,
    output logic [width-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - width'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/nco_tune_ctrl.sv
// Tuning sequencer in front of the NCO core: accepts jump/ramp retune
// commands, steps the frequency word, then waits out the NCO latency.
//
// state  | meaning
// IDLE   | ready for a command; settled reports the last command finished
// RAMP   | applying dwell-timed frequency steps through freq_mod_o
// SETTLE | final word applied, waiting nco_lat enabled cycles
module nco_tune_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int apr     = 16,
    parameter int aprp    = 16,
    parameter int stw     = 8,
    parameter int dww     = 16,
    parameter int nco_lat = NCO_LAT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [apr-1:0]  cmd_phi_inc,
    input  logic [apr-1:0]  cmd_step,
    input  logic [stw-1:0]  cmd_nsteps,
    input  logic [dww-1:0]  cmd_dwell,
    input  logic [aprp-1:0] cmd_phase,
    input  logic            abort,
    output logic [apr-1:0]  phi_inc_o,
    output logic [apr-1:0]  freq_mod_o,
    output logic [aprp-1:0] phase_mod_o,
    output logic            nco_clken,
    output logic            busy,
    output logic            settled
);

    localparam int lw = (nco_lat > 1) ? $clog2(nco_lat) : 1;

    state_t          state_q, state_d;
    logic [apr-1:0]  phi_q, phi_d;
    logic [apr-1:0]  fm_q, fm_d;
    logic [aprp-1:0] ph_q, ph_d;
    logic [apr-1:0]  step_q, step_d;
    logic [dww-1:0]  dp_q, dp_d;
    logic [stw-1:0]  scnt_q, scnt_d;
    logic            settled_q, settled_d;
    logic            clken_q;

    logic [dww-1:0]  dw_eff;
    logic            d_load, d_en, d_zero;
    logic [dww-1:0]  d_val, dcnt;
    logic            l_load, l_en, l_zero;
    logic [lw-1:0]   lcnt;

    nco_ctrl_dwell_cnt #(.width(dww)) u_dcnt (
        .clk      (clk),
        .reset    (reset),
        .load     (d_load),
        .load_val (d_val),
        .en       (d_en),
        .cnt      (dcnt),
        .zero     (d_zero)
    );

    nco_ctrl_dwell_cnt #(.width(lw)) u_lcnt (
        .clk      (clk),
        .reset    (reset),
        .load     (l_load),
        .load_val (lw'(nco_lat - 1)),
        .en       (l_en),
        .cnt      (lcnt),
        .zero     (l_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            phi_q     <= '0;
            fm_q      <= '0;
            ph_q      <= '0;
            step_q    <= '0;
            dp_q      <= '0;
            scnt_q    <= '0;
            settled_q <= 1'b0;
            clken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            phi_q     <= phi_d;
            fm_q      <= fm_d;
            ph_q      <= ph_d;
            step_q    <= step_d;
            dp_q      <= dp_d;
            scnt_q    <= scnt_d;
            settled_q <= settled_d;
            clken_q   <= run;
        end
    end

    always_comb begin
        state_d   = state_q;
        phi_d     = phi_q;
        fm_d      = fm_q;
        ph_d      = ph_q;
        step_d    = step_q;
        dp_d      = dp_q;
        scnt_d    = scnt_q;
        settled_d = settled_q;
        d_load    = 1'b0;
        d_val     = dp_q - dww'(1);
        d_en      = 1'b0;
        l_load    = 1'b0;
        l_en      = 1'b0;
        dw_eff    = (cmd_dwell == '0) ? dww'(1) : cmd_dwell;

        case (state_q)
            IDLE: begin
                // Accept is deliberately not gated by nco_clken.
                if (cmd_valid) begin
                    phi_d     = cmd_phi_inc;
                    fm_d      = '0;
                    ph_d      = cmd_phase;
                    settled_d = 1'b0;
                    step_d    = cmd_step;
                    dp_d      = dw_eff;
                    d_load    = 1'b1;
                    d_val     = dw_eff - dww'(1);
                    scnt_d    = cmd_nsteps;
                    if (cmd_nsteps != '0) begin
                        state_d = RAMP;
                    end else begin
                        state_d = SETTLE;
                        l_load  = 1'b1;
                    end
                end
            end
            RAMP: begin
                if (clken_q) begin
                    if (abort) begin
                        phi_d   = phi_q + fm_q;
                        fm_d    = '0;
                        state_d = IDLE;
                    end else if (!d_zero) begin
                        d_en = 1'b1;
                    end else if (scnt_q == stw'(1)) begin
                        // Fold the last step so phi+fm seen by the NCO is continuous.
                        phi_d   = phi_q + fm_q + step_q;
                        fm_d    = '0;
                        scnt_d  = '0;
                        state_d = SETTLE;
                        l_load  = 1'b1;
                    end else begin
                        fm_d   = fm_q + step_q;
                        scnt_d = scnt_q - stw'(1);
                        d_load = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (clken_q) begin
                    if (abort) begin
                        phi_d   = phi_q + fm_q;
                        fm_d    = '0;
                        state_d = IDLE;
                    end else if (l_zero) begin
                        settled_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        l_en = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign phi_inc_o   = phi_q;
    assign freq_mod_o  = fm_q;
    assign phase_mod_o = ph_q;
    assign nco_clken   = clken_q;
    assign settled     = settled_q;

endmodule

// File: tb/tb_nco_tune_ctrl.sv
// Self-checking bench for nco_tune_ctrl: directed test-plan steps plus
// randomized commands checked against an enabled-cycle timing model.
module tb_nco_tune_ctrl;

    localparam int LAT = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_phi_inc;
    logic [15:0] cmd_step;
    logic [7:0]  cmd_nsteps;
    logic [15:0] cmd_dwell;
    logic [15:0] cmd_phase;
    logic        abort;
    logic [15:0] phi_inc_o;
    logic [15:0] freq_mod_o;
    logic [15:0] phase_mod_o;
    logic        nco_clken;
    logic        busy;
    logic        settled;

    nco_tune_ctrl #(
        .apr(16), .aprp(16), .stw(8), .dww(16), .nco_lat(LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_phi_inc (cmd_phi_inc),
        .cmd_step    (cmd_step),
        .cmd_nsteps  (cmd_nsteps),
        .cmd_dwell   (cmd_dwell),
        .cmd_phase   (cmd_phase),
        .abort       (abort),
        .phi_inc_o   (phi_inc_o),
        .freq_mod_o  (freq_mod_o),
        .phase_mod_o (phase_mod_o),
        .nco_clken   (nco_clken),
        .busy        (busy),
        .settled     (settled)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_acc = 0;

    // Reference model: outputs are derived from the number of enabled edges
    // since the accepting edge, using the documented step/settle timing.
    bit          m_busy, m_settled, m_clken;
    int          e, m_n, m_dp;
    logic [15:0] m_phi0, m_step, m_phi_idle, m_ph;

    function automatic int steps_done();
        int k;
        k = e / m_dp;
        if (k > m_n) k = m_n;
        return k;
    endfunction

    function automatic logic [15:0] exp_phi();
        logic [15:0] r;
        if (!m_busy) return m_phi_idle;
        r = m_phi0;
        if (m_n > 0 && steps_done() == m_n) r = m_phi0 + m_step * 16'(m_n);
        return r;
    endfunction

    function automatic logic [15:0] exp_fm();
        logic [15:0] r;
        r = '0;
        if (m_busy && steps_done() < m_n) r = m_step * 16'(steps_done());
        return r;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_settled = 0; m_clken = 0; e = 0;
        m_phi_idle = '0; m_ph = '0; m_phi0 = '0; m_step = '0; m_n = 0; m_dp = 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".phi"},     32'(phi_inc_o),   32'(exp_phi()));
        chk({tag, ".fm"},      32'(freq_mod_o),  32'(exp_fm()));
        chk({tag, ".ph"},      32'(phase_mod_o), 32'(m_ph));
        chk({tag, ".clken"},   32'(nco_clken),   32'(m_clken));
        chk({tag, ".busy"},    32'(busy),        32'(m_busy));
        chk({tag, ".settled"}, 32'(settled),     32'(m_settled));
        chk({tag, ".ready"},   32'(cmd_ready),   32'(!m_busy));
    endtask

    task automatic tick();
        bit en_edge, acc;
        logic [15:0] cur;
        en_edge = m_clken;
        acc = !m_busy && cmd_valid;
        @(posedge clk);
        cyc++;
        if (acc) begin
            m_busy = 1; m_settled = 0; e = 0;
            m_phi0 = cmd_phi_inc; m_step = cmd_step; m_ph = cmd_phase;
            m_n = int'(cmd_nsteps);
            m_dp = (cmd_dwell == 0) ? 1 : int'(cmd_dwell);
        end else if (m_busy && en_edge) begin
            if (abort) begin
                cur = exp_phi() + exp_fm();
                m_phi_idle = cur;
                m_busy = 0;
            end else begin
                e++;
                if (e >= m_n * m_dp + LAT) begin
                    m_phi_idle = m_phi0 + m_step * 16'(m_n);
                    m_busy = 0;
                    m_settled = 1;
                end
            end
        end
        m_clken = run;
        #1;
    endtask

    task automatic start_cmd(input string tag, input logic [15:0] phi, input logic [15:0] stp,
                             input logic [7:0] n, input logic [15:0] dw, input logic [15:0] ph);
        cmd_phi_inc = phi; cmd_step = stp; cmd_nsteps = n; cmd_dwell = dw; cmd_phase = ph;
        cmd_valid = 1;
        tick();
        t_acc = cyc;
        check_all({tag, ".acc"});
        cmd_valid = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (m_busy && k < budget) begin
            tick();
            check_all(tag);
            k++;
        end
        chk({tag, ".done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int t_set;
        int n_r, dw_r;
        reset = 1; run = 0; cmd_valid = 0; abort = 0;
        cmd_phi_inc = '0; cmd_step = '0; cmd_nsteps = '0; cmd_dwell = '0; cmd_phase = '0;
        model_reset();
        #1;
        check_all("reset");
        #20 reset = 0;
        run = 1;
        tick(); check_all("run_on");
        tick(); check_all("run_on");

        // Jump
        start_cmd("jump", 16'h1000, 16'h0000, 8'd0, 16'd0, 16'h0040);
        chk("jump.phi_t1", 32'(phi_inc_o), 32'h1000);
        wait_done("jump", 40);
        chk("jump.settle_time", 32'(cyc - t_acc), 32'(LAT));

        // Abort ignored in IDLE
        abort = 1; tick(); check_all("idle_abort"); abort = 0;

        // Ramp
        start_cmd("ramp", 16'h1000, 16'h0100, 8'd4, 16'd3, 16'h0000);
        repeat (3) begin tick(); check_all("ramp"); end
        chk("ramp.fm_t3", 32'(freq_mod_o), 32'h0100);
        repeat (9) begin tick(); check_all("ramp"); end
        chk("ramp.phi_t12", 32'(phi_inc_o), 32'h1400);
        chk("ramp.fm_t12", 32'(freq_mod_o), 32'h0000);
        wait_done("ramp", 60);
        chk("ramp.settle_time", 32'(cyc - t_acc), 32'(4 * 3 + LAT));

        // Negative wrap
        start_cmd("wrap", 16'h0080, 16'hFF00, 8'd1, 16'd0, 16'h1234);
        tick(); check_all("wrap");
        chk("wrap.phi_t1", 32'(phi_inc_o), 32'hFF80);
        wait_done("wrap", 40);

        // Abort at T+7
        start_cmd("abort", 16'h1000, 16'h0100, 8'd4, 16'd3, 16'h0000);
        repeat (6) begin tick(); check_all("abort"); end
        abort = 1; tick(); abort = 0;
        check_all("abort_edge");
        chk("abort.phi", 32'(phi_inc_o), 32'h1200);
        chk("abort.settled", 32'(settled), 32'd0);

        // Clock gating: run low for 5 cycles mid-ramp
        start_cmd("gate", 16'h1000, 16'h0100, 8'd4, 16'd3, 16'h0000);
        repeat (4) begin tick(); check_all("gate"); end
        run = 0;
        tick(); check_all("gate_off");
        chk("gate.clken_still_on", 32'(nco_clken), 32'd0);
        repeat (4) begin tick(); check_all("gate_off"); end
        run = 1;
        t_set = 0;
        for (int i = 0; i < 60; i++) begin
            tick(); check_all("gate");
            if (settled && t_set == 0) t_set = cyc - t_acc;
            if (!m_busy) break;
        end
        chk("gate.settle_time", 32'(t_set), 32'(4 * 3 + LAT + 5));

        // Randomized commands with clock gating, aborts and unwanted cmd_valid
        for (int c = 0; c < 25; c++) begin
            n_r = int'($urandom_range(0, 5));
            dw_r = int'($urandom_range(0, 4));
            start_cmd("rnd", 16'($urandom), 16'($urandom), 8'(n_r), 16'(dw_r), 16'($urandom));
            for (int i = 0; i < 400 && m_busy; i++) begin
                run = ($urandom_range(0, 7) != 0);
                abort = ($urandom_range(0, 59) == 0);
                cmd_valid = ($urandom_range(0, 3) == 0);
                cmd_phi_inc = 16'($urandom);
                tick(); check_all("rnd");
            end
            run = 1; abort = 0; cmd_valid = 0;
            chk("rnd.done", 32'(busy), 32'd0);
            tick(); check_all("rnd_idle");
        end

        // Asynchronous reset mid-SETTLE
        start_cmd("rst", 16'h2222, 16'h0000, 8'd0, 16'd0, 16'h0777);
        repeat (3) begin tick(); check_all("rst_pre"); end
        #2 reset = 1;
        model_reset();
        #1;
        check_all("rst_async");
        #2 reset = 0;
        tick(); check_all("rst_after");
        chk("rst.ready", 32'(cmd_ready), 32'd1);
        start_cmd("post_rst", 16'h0F00, 16'h0010, 8'd2, 16'd2, 16'h0001);
        wait_done("post_rst", 60);
        chk("post_rst.phi", 32'(phi_inc_o), 32'h0F20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nco_tune_ctrl.md
# nco_tune_ctrl

Tuning sequencer placed in front of the NCO core. It accepts retune commands over a valid/ready handshake and drives the core's `phi_inc_i`, `freq_mod_i` and `phase_mod_i` inputs and its `clken`. A retune is either a jump or a linear frequency ramp of N dwell-timed steps. After the last step the block waits out the core's pipeline latency, then reports `settled`, so the ASK receiver knows when the NCO output reflects the new frequency.

## Interface
Parameters:
- `apr`, 16: phase-increment width; equals the NCO `apr`/`aprf`.
- `aprp`, 16: phase-offset width; equals the NCO `aprp`.
- `stw`, 8: step-count width.
- `dww`, 16: dwell-count width.
- `nco_lat`, 12: NCO input-to-output latency in enabled cycles; must be ≥ 1.

Ports (one per line: name, direction, width, meaning):
- `clk`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `run`, in, 1: enable request for the NCO.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: block can accept a command.
- `cmd_phi_inc`, in, apr: start frequency word.
- `cmd_step`, in, apr: per-step increment, two's complement.
- `cmd_nsteps`, in, stw: number of ramp steps; 0 = jump.
- `cmd_dwell`, in, dww: cycles per step; 0 is treated as 1.
- `cmd_phase`, in, aprp: phase offset.
- `abort`, in, 1: terminate the current command.
- `phi_inc_o`, out, apr: to NCO `phi_inc_i`.
- `freq_mod_o`, out, apr: to NCO `freq_mod_i`.
- `phase_mod_o`, out, aprp: to NCO `phase_mod_i`.
- `nco_clken`, out, 1: to NCO `clken`.
- `busy`, out, 1: state is not IDLE.
- `settled`, out, 1: last command has fully propagated.

## Operation
- Every output is registered. Reset values: `phi_inc_o`=0, `freq_mod_o`=0, `phase_mod_o`=0, `nco_clken`=0, `busy`=0, `settled`=0; state is IDLE.
- `nco_clken` is `run` delayed by one register.
- All counters and state transitions advance only in cycles where `nco_clken`=1. The handshake in IDLE is not gated.
- States: IDLE, RAMP, SETTLE.
- IDLE:
  - `cmd_ready`=1 (combinational from state).
  - On accept (`cmd_valid` & `cmd_ready`): `phi_inc_o`←`cmd_phi_inc`, `freq_mod_o`←0, `phase_mod_o`←`cmd_phase`, `settled`←0.
  - Latch `step` and `d'`=max(`cmd_dwell`,1). Load `dcnt`←`d'`−1 and `scnt`←`cmd_nsteps`.
  - Next state is RAMP if `cmd_nsteps`≠0. Otherwise the next state is SETTLE with `lcnt`←`nco_lat`−1.
- RAMP:
  - If `dcnt`≠0, `dcnt`−−.
  - Otherwise `freq_mod_o`←`freq_mod_o`+`step` (mod 2^apr), `scnt`−−, `dcnt`←`d'`−1.
  - On the edge that applies the last step (`scnt`=1), fold instead: `phi_inc_o`←`phi_inc_o`+`freq_mod_o`+`step`, `freq_mod_o`←0. Then go to SETTLE with `lcnt`←`nco_lat`−1.
  - The fold keeps `phi_inc_o`+`freq_mod_o` unchanged from the NCO's view.
- SETTLE: `lcnt`−−. When `lcnt`=0, go to IDLE with `settled`←1.
- `abort`:
  - In RAMP or SETTLE, it wins over every other action. Fold `phi_inc_o`←`phi_inc_o`+`freq_mod_o`, `freq_mod_o`←0, go to IDLE, and leave `settled`=0.
  - Ignored in IDLE.
- `settled` stays high in IDLE until the next command is accepted.
- Frequency words wrap modulo 2^apr. There is no saturation.

## Timing
- Accept at edge T, so NCO inputs are updated from cycle T+1.
- Step k (1..n) appears at edge T+k·d'. Step n appears folded into `phi_inc_o`.
- `settled` rises at edge T+n·d'+`nco_lat`. For a jump (n=0) it rises at T+`nco_lat`.
- The periods above count enabled cycles only. Each disabled cycle (`nco_clken`=0) adds one cycle.
- `cmd_valid` in the same cycle that the block returns to IDLE is not accepted until the next cycle, because `cmd_ready` is derived from state.
- An asynchronous `reset` mid-command returns the block to IDLE immediately and clears all outputs.

## Structure
- Shared package `nco_ctrl_pkg` holds the state enum (IDLE/RAMP/SETTLE) and the default `nco_lat` constant. Its default `nco_lat` must match the out_valid latency of the NCO wrapper.
- The block is one module, `nco_tune_ctrl`, with one natural sub-module `nco_ctrl_dwell_cnt`: a loadable down-counter with zero flag and enable, instantiated for `dcnt` and `lcnt`.

## Test plan
- Jump: reset, `run`=1, command phi=0x1000, n=0. Expect `phi_inc_o`=0x1000 from T+1, `busy` for 12 cycles, `settled` at T+12, `freq_mod_o`=0 throughout.
- Ramp: phi=0x1000, step=0x0100, n=4, dwell=3. Expect `freq_mod_o`=0x100/0x200/0x300 at T+3/6/9, then at T+12 `phi_inc_o`=0x1400 and `freq_mod_o`=0, then `settled` at T+24.
- Negative wrap: phi=0x0080, step=0xFF00, n=1, dwell=0. Expect at T+1 `phi_inc_o`=0xFF80 and `freq_mod_o`=0.
- Abort: abort the ramp above at T+7. Expect `phi_inc_o`=0x1200, `freq_mod_o`=0, IDLE, and `settled`=0.
- Clock gating: drop `run` for 5 cycles during the ramp. Expect `nco_clken` low one cycle later and every step and `settled` delayed by exactly 5 cycles.
- Reset mid-SETTLE: assert `reset`. Expect all outputs 0 asynchronously, `cmd_ready`=1 after release, and a new command accepted normally.
